wb_stage: RTL and testbench



---
 rtl/wb_stage.sv | 151 +++++++++++++++
 tb/tb_wb_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM->WB stage register under stall control, regfile write/forward buses, architectural HI/LO.
// Optional trace ports are enabled with `define WB_DEBUG_TRACE_EN.
module wb_stage #(
    parameter int          MEM_TO_WB_WD = 135,
    parameter int          WB_TO_RF_WD  = 38,
    parameter int          WB_TO_ID_WD  = 38,
    parameter logic [31:0] RST_PC       = 32'hbfc00000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               stall,
    input  logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus,
    output logic [WB_TO_RF_WD-1:0]   wb_to_rf_bus,
    output logic [WB_TO_ID_WD-1:0]   wb_to_id_bus,
    output logic [65:0]              wb_to_ex_hilo,
`ifdef WB_DEBUG_TRACE_EN
    output logic [31:0]              debug_wb_pc,
    output logic [3:0]               debug_wb_rf_wen,
    output logic [4:0]               debug_wb_rf_wnum,
    output logic [31:0]              debug_wb_rf_wdata,
`endif
    output logic [31:0]              hi_o,
    output logic [31:0]              lo_o
);

    // The 135-bit bus carries pc[31:1]; fetch addresses are aligned, so pc[0] is rebuilt as 0.
    localparam int LO_D_LSB  = 0;
    localparam int HI_D_LSB  = 32;
    localparam int LO_WE_BIT = 64;
    localparam int HI_WE_BIT = 65;
    localparam int RF_WD_LSB = 66;
    localparam int RF_WA_LSB = 98;
    localparam int RF_WE_BIT = 103;
    localparam int PC_LSB    = 104;

    logic [31:0] in_pc;
    logic        in_rf_we;
    logic [4:0]  in_rf_waddr;
    logic [31:0] in_rf_wdata;
    logic        in_hi_we;
    logic        in_lo_we;
    logic [31:0] in_hi_wdata;
    logic [31:0] in_lo_wdata;

    logic [31:0] pc_q,       pc_d;
    logic        rf_we_q,    rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        hi_we_q,    hi_we_d;
    logic        lo_we_q,    lo_we_d;
    logic [31:0] hi_wdata_q, hi_wdata_d;
    logic [31:0] lo_wdata_q, lo_wdata_d;
    logic [31:0] hi_q,       hi_d;
    logic [31:0] lo_q,       lo_d;

    logic        mem_stall;
    logic        wb_stall;
    logic        unused_stall;

    assign mem_stall    = stall[4];
    assign wb_stall     = stall[5];
    assign unused_stall = ^stall[3:0];

    always_comb begin
        in_pc       = {mem_to_wb_bus[PC_LSB +: 31], 1'b0};
        in_rf_we    = mem_to_wb_bus[RF_WE_BIT];
        in_rf_waddr = mem_to_wb_bus[RF_WA_LSB +: 5];
        in_rf_wdata = mem_to_wb_bus[RF_WD_LSB +: 32];
        in_hi_we    = mem_to_wb_bus[HI_WE_BIT];
        in_lo_we    = mem_to_wb_bus[LO_WE_BIT];
        in_hi_wdata = mem_to_wb_bus[HI_D_LSB +: 32];
        in_lo_wdata = mem_to_wb_bus[LO_D_LSB +: 32];
    end

    // Stage register next state: bubble beats capture, capture beats hold.
    always_comb begin
        pc_d       = pc_q;
        rf_we_d    = rf_we_q;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        hi_we_d    = hi_we_q;
        lo_we_d    = lo_we_q;
        hi_wdata_d = hi_wdata_q;
        lo_wdata_d = lo_wdata_q;
        if (mem_stall && !wb_stall) begin
            pc_d       = 32'd0;
            rf_we_d    = 1'b0;
            rf_waddr_d = 5'd0;
            rf_wdata_d = 32'd0;
            hi_we_d    = 1'b0;
            lo_we_d    = 1'b0;
            hi_wdata_d = 32'd0;
            lo_wdata_d = 32'd0;
        end else if (!mem_stall) begin
            pc_d       = in_pc;
            rf_we_d    = in_rf_we;
            rf_waddr_d = in_rf_waddr;
            rf_wdata_d = in_rf_wdata;
            hi_we_d    = in_hi_we;
            lo_we_d    = in_lo_we;
            hi_wdata_d = in_hi_wdata;
            lo_wdata_d = in_lo_wdata;
        end
    end

    // HI/LO commit from the stage register regardless of stall; a held write is simply repeated.
    always_comb begin
        hi_d = hi_we_q ? hi_wdata_q : hi_q;
        lo_d = lo_we_q ? lo_wdata_q : lo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RST_PC;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            hi_we_q    <= 1'b0;
            lo_we_q    <= 1'b0;
            hi_wdata_q <= 32'd0;
            lo_wdata_q <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            hi_we_q    <= hi_we_d;
            lo_we_q    <= lo_we_d;
            hi_wdata_q <= hi_wdata_d;
            lo_wdata_q <= lo_wdata_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign wb_to_rf_bus  = {rf_we_q, rf_waddr_q, rf_wdata_q};
    assign wb_to_id_bus  = {rf_we_q, rf_waddr_q, rf_wdata_q};
    assign wb_to_ex_hilo = {hi_we_q, lo_we_q, hi_wdata_q, lo_wdata_q};
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_wen   = {4{rf_we_q}};
    assign debug_wb_rf_wnum  = rf_waddr_q;
    assign debug_wb_rf_wdata = rf_wdata_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by randomized traffic against a bus-level model.
module tb_wb_stage;

    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [134:0] mem_to_wb_bus;
    logic [37:0]  wb_to_rf_bus;
    logic [37:0]  wb_to_id_bus;
    logic [65:0]  wb_to_ex_hilo;
    logic [31:0]  hi_o;
    logic [31:0]  lo_o;
`ifdef WB_DEBUG_TRACE_EN
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_wen;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;
`endif

    int errors = 0;
    int checks = 0;

    // Model: the stage holds a copy of the last accepted bus word; HI/LO are plain registers.
    logic [134:0] m_word;
    logic [31:0]  m_hi;
    logic [31:0]  m_lo;

    always #5 clk = ~clk;

    wb_stage #(
        .MEM_TO_WB_WD(135),
        .WB_TO_RF_WD (38),
        .WB_TO_ID_WD (38),
        .RST_PC      (RST_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .wb_to_rf_bus     (wb_to_rf_bus),
        .wb_to_id_bus     (wb_to_id_bus),
        .wb_to_ex_hilo    (wb_to_ex_hilo),
`ifdef WB_DEBUG_TRACE_EN
        .debug_wb_pc      (debug_wb_pc),
        .debug_wb_rf_wen  (debug_wb_rf_wen),
        .debug_wb_rf_wnum (debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata),
`endif
        .hi_o             (hi_o),
        .lo_o             (lo_o)
    );

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [134:0] mk(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                        input logic [31:0] wd, input logic hwe, input logic lwe,
                                        input logic [31:0] hd, input logic [31:0] ld);
        return {pc[31:1], we, wa, wd, hwe, lwe, hd, ld};
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_word = {RST_PC[31:1], 104'd0};
        end else begin
            if (m_word[65]) m_hi = m_word[63:32];
            if (m_word[64]) m_lo = m_word[31:0];
            if (!stall[4])      m_word = mem_to_wb_bus;
            else if (!stall[5]) m_word = '0;
        end
    endtask

    task automatic check_all();
        check("rf_bus",   {28'd0, wb_to_rf_bus}, {28'd0, m_word[103:66]});
        check("id_bus",   {28'd0, wb_to_id_bus}, {28'd0, m_word[103:66]});
        check("ex_hilo",  wb_to_ex_hilo, m_word[65:0]);
        check("hi",       {34'd0, hi_o}, {34'd0, m_hi});
        check("lo",       {34'd0, lo_o}, {34'd0, m_lo});
`ifdef WB_DEBUG_TRACE_EN
        check("dbg_pc",   {34'd0, debug_wb_pc}, {34'd0, m_word[134:104], 1'b0});
        check("dbg_wen",  {62'd0, debug_wb_rf_wen}, {62'd0, {4{m_word[103]}}});
        check("dbg_wnum", {61'd0, debug_wb_rf_wnum}, {61'd0, m_word[102:98]});
        check("dbg_wdat", {34'd0, debug_wb_rf_wdata}, {34'd0, m_word[97:66]});
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        m_word        = '0;
        m_hi          = '0;
        m_lo          = '0;
        rst           = 1'b1;
        stall         = 6'd0;
        mem_to_wb_bus = mk(32'h1234_5678, 1'b1, 5'd3, 32'hdead_beef, 1'b1, 1'b1, 32'h1, 32'h2);
        tick();
        tick();
        check("rst_rf", {28'd0, wb_to_rf_bus}, 66'd0);
        check("rst_hi", {34'd0, hi_o}, 66'd0);
`ifdef WB_DEBUG_TRACE_EN
        check("rst_pc", {34'd0, debug_wb_pc}, {34'd0, 32'hbfc00000});
`endif
        rst = 1'b0;

        // Normal flow
        mem_to_wb_bus = mk(32'hbfc00010, 1'b1, 5'd8, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("flow_rf", {28'd0, wb_to_rf_bus}, {28'd0, 1'b1, 5'd8, 32'h12345678});
        check("flow_id", {28'd0, wb_to_id_bus}, {28'd0, 1'b1, 5'd8, 32'h12345678});

        // Hold, then bubble
        mem_to_wb_bus = mk(32'hbfc00014, 1'b1, 5'd9, 32'h0badf00d, 1'b0, 1'b0, 32'h0, 32'h0);
        stall = 6'b111111;
        tick();
        check("hold_rf", {28'd0, wb_to_rf_bus}, {28'd0, 1'b1, 5'd8, 32'h12345678});
        stall = 6'b011111;
        tick();
        check("bubble_rf", {28'd0, wb_to_rf_bus}, 66'd0);
        stall = 6'd0;

        // HI/LO pair, then HI only
        mem_to_wb_bus = mk(32'hbfc00020, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'hAAAA0000, 32'h0000BBBB);
        tick();
        check("hilo_fwd", wb_to_ex_hilo, {1'b1, 1'b1, 32'hAAAA0000, 32'h0000BBBB});
        check("hi_pre", {34'd0, hi_o}, 66'd0);
        mem_to_wb_bus = mk(32'hbfc00024, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h11112222, 32'h33334444);
        tick();
        check("hi_commit", {34'd0, hi_o}, {34'd0, 32'hAAAA0000});
        check("lo_commit", {34'd0, lo_o}, {34'd0, 32'h0000BBBB});
        mem_to_wb_bus = '0;
        tick();
        check("hi_only_hi", {34'd0, hi_o}, {34'd0, 32'h11112222});
        check("hi_only_lo", {34'd0, lo_o}, {34'd0, 32'h0000BBBB});

        // Reset beats stall; pending HI write discarded
        mem_to_wb_bus = mk(32'hbfc00030, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h55555555, 32'h66666666);
        tick();
        rst = 1'b1;
        stall = 6'b111111;
        mem_to_wb_bus = mk(32'hbfc00034, 1'b1, 5'd7, 32'hcafe0000, 1'b1, 1'b1, 32'h7, 32'h8);
        tick();
        check("prio_rf", {28'd0, wb_to_rf_bus}, 66'd0);
        check("prio_hi", {34'd0, hi_o}, 66'd0);
        check("prio_hilo", wb_to_ex_hilo, 66'd0);
        rst = 1'b0;
        stall = 6'd0;

        // Back-to-back writes to r1..r4
        for (int r = 1; r <= 4; r++) begin
            mem_to_wb_bus = mk(32'hbfc00040 + 32'(4 * r), 1'b1, 5'(r), 32'(r * 32'h01010101),
                               1'b0, 1'b0, 32'h0, 32'h0);
            tick();
            check("b2b_wa", {61'd0, wb_to_rf_bus[36:32]}, {61'd0, 5'(r)});
`ifdef WB_DEBUG_TRACE_EN
            check("trace_wen", {62'd0, debug_wb_rf_wen}, {62'd0, 4'hf});
            check("trace_wnum", {61'd0, debug_wb_rf_wnum}, {61'd0, 5'(r)});
`endif
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    stall = 6'b011111;
                2:       stall = 6'b111111;
                3:       stall = 6'($urandom);
                default: stall = 6'd0;
            endcase
            rst = ($urandom_range(0, 39) == 0);
            mem_to_wb_bus = mk({$urandom, 1'b0} >> 1 << 1, 1'($urandom), 5'($urandom), $urandom,
                               1'($urandom), 1'($urandom), $urandom, $urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
